// File: rtl/ex_stage_muldiv.sv
// RV32IM execute stage: single-cycle ALU plus an iterative radix-2 mul/div unit,
// with results registered into the EX/MEM boundary behind a valid/ready handshake.
module ex_stage_muldiv #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_addr,
    input  logic            rd_write_en,
    input  logic [1:0]      dest_sel,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_write_en,
    output logic [1:0]      out_dest_sel,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [4:0] LAST_STEP = 5'(MD_STEPS - 1);
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d, op_q, op_d, rd_q, rd_d;
    logic            neg_q, neg_d, we_q, we_d;
    logic [1:0]      dsel_q, dsel_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, pc_q, pc_d;
    logic            out_valid_q, out_valid_d, out_we_q, out_we_d;
    logic [XLEN-1:0] out_result_q, out_result_d, out_pc_q, out_pc_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [1:0]      out_dsel_q, out_dsel_d;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready never depends on in_valid; out_valid, once high, holds its data until out_ready.
    logic accept;
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    logic            is_m, is_div, is_rem, a_signed, b_signed, a_neg, b_neg, res_neg;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res, alu_res;

    always_comb begin
        is_m     = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
        is_div   = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
        is_rem   = (alu_op == OP_REM) || (alu_op == OP_REMU);
        a_signed = (alu_op == OP_MUL) || (alu_op == OP_MULH) || (alu_op == OP_MULHSU)
                || (alu_op == OP_DIV) || (alu_op == OP_REM);
        b_signed = (alu_op == OP_MUL) || (alu_op == OP_MULH)
                || (alu_op == OP_DIV) || (alu_op == OP_REM);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        a_mag    = a_neg ? -operand_a : operand_a;
        b_mag    = b_neg ? -operand_b : operand_b;
        // Remainder follows the dividend; quotient and product follow the xor of signs.
        res_neg  = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (operand_b == '0);
        div_ovf  = ((alu_op == OP_DIV) || (alu_op == OP_REM))
                && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) fast_res = is_rem ? operand_a : '1;
        else          fast_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        case (alu_op)
            5'd0:    alu_res = operand_a + operand_b;
            5'd1:    alu_res = operand_a - operand_b;
            5'd2:    alu_res = operand_a << operand_b[4:0];
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            5'd5:    alu_res = operand_a ^ operand_b;
            5'd6:    alu_res = operand_a >> operand_b[4:0];
            5'd7:    alu_res = $signed(operand_a) >>> operand_b[4:0];
            5'd8:    alu_res = operand_a | operand_b;
            5'd9:    alu_res = operand_a & operand_b;
            default: alu_res = '0;
        endcase
    end

    // One iteration: mul keeps {acc, multiplier} in {hi, lo}; div keeps {remainder, dividend}.
    logic [XLEN:0]     mul_sum, div_shl, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quo, rem, md_res;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shl  = {hi_q, lo_q[XLEN-1]};
        div_diff = div_shl - {1'b0, b_q};
        if (op_q <= OP_MULHU) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_diff[XLEN] ? div_shl[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], !div_diff[XLEN]};
        end
        prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo    = neg_q ? -step_lo : step_lo;
        rem    = neg_q ? -step_hi : step_hi;
        case (op_q)
            OP_MUL:                       md_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              md_res = quo;
            default:                      md_res = rem;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        neg_d        = neg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        b_d          = b_q;
        rd_d         = rd_q;
        we_d         = we_q;
        dsel_d       = dsel_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_we_d     = out_we_q;
        out_dsel_d   = out_dsel_q;
        out_pc_d     = out_pc_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (!is_m || fast)) begin
                    out_valid_d  = 1'b1;
                    out_result_d = is_m ? fast_res : alu_res;
                    out_rd_d     = rd_addr;
                    out_we_d     = rd_write_en;
                    out_dsel_d   = dest_sel;
                    out_pc_d     = pc;
                end else if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    op_d    = alu_op;
                    neg_d   = res_neg;
                    hi_d    = '0;
                    lo_d    = is_div ? a_mag : b_mag;
                    b_d     = is_div ? b_mag : a_mag;
                    rd_d    = rd_addr;
                    we_d    = rd_write_en;
                    dsel_d  = dest_sel;
                    pc_d    = pc;
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    out_valid_d  = 1'b1;
                    out_result_d = md_res;
                    out_rd_d     = rd_q;
                    out_we_d     = we_q;
                    out_dsel_d   = dsel_q;
                    out_pc_d     = pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            b_q          <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            dsel_q       <= '0;
            pc_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_dsel_q   <= '0;
            out_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            b_q          <= b_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            dsel_q       <= dsel_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_we_q     <= out_we_d;
            out_dsel_q   <= out_dsel_d;
            out_pc_q     <= out_pc_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_result      = out_result_q;
    assign out_rd_addr     = out_rd_q;
    assign out_rd_write_en = out_we_q;
    assign out_dest_sel    = out_dsel_q;
    assign out_pc          = out_pc_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed and randomized bench for ex_stage_muldiv: every accepted op pushes its expected
// writeback onto exp_q, and a negedge monitor pops and compares on each output handshake.
module tb_ex_stage_muldiv;

    logic        clk, arstn, flush, in_valid, in_ready, rd_write_en, out_valid, out_ready;
    logic        out_rd_write_en;
    logic [4:0]  alu_op, rd_addr, out_rd_addr;
    logic [1:0]  dest_sel, out_dest_sel;
    logic [31:0] operand_a, operand_b, pc, out_result, out_pc;

    int          total = 0;
    int          bad   = 0;
    logic [71:0] exp_q[$];
    logic [71:0] mon_got, mon_want;

    ex_stage_muldiv dut (
        .clk(clk), .arstn(arstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
        .rd_addr(rd_addr), .rd_write_en(rd_write_en), .dest_sel(dest_sel), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd_addr(out_rd_addr), .out_rd_write_en(out_rd_write_en),
        .out_dest_sel(out_dest_sel), .out_pc(out_pc)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results written directly from the RV32IM definitions.
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return {31'b0, $signed(a) < $signed(b)};
            5'd4:  return {31'b0, a < b};
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: begin p = sa * sb; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * ub; return p[63:32]; end
            5'd13: begin p = ua * ub; return p[63:32]; end
            5'd14: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            5'd15: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            5'd16: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            5'd17: begin if (b == 0) return a; return a % b; end
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (arstn && out_valid && out_ready) begin
            mon_got = {out_pc, out_dest_sel, out_rd_write_en, out_rd_addr, out_result};
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", mon_got);
            end
            if (exp_q.size() > 0) begin
                mon_want = exp_q.pop_front();
                total++;
                assert (mon_got === mon_want) else begin
                    bad++;
                    $error("FAIL sb_data observed=%h expected=%h", mon_got, mon_want);
                end
            end
        end
    end

    // Driver tasks
    task automatic set_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] p);
        alu_op      = op;
        operand_a   = a;
        operand_b   = b;
        rd_addr     = rd;
        rd_write_en = ~rd[0];
        dest_sel    = p[3:2];
        pc          = p;
        in_valid    = 1'b1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] p, input logic [31:0] exp);
        set_in(op, a, b, rd, p);
        exp_q.push_back({p, p[3:2], ~rd[0], rd, exp});
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        alu_op    = 5'($urandom_range(0, 31));
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] p,
                          input logic [31:0] exp, input int exp_edges);
        int edges, busy_low;
        drive(op, a, b, rd, p, exp);
        wait_accept(tag);
        edges    = 0;
        busy_low = 0;
        while (!out_valid && edges < 100) begin
            if (!in_ready) busy_low++;
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'(exp_edges));
        if (exp_edges > 0) chk({tag, "_busy"}, 32'(busy_low), 32'(exp_edges));
        chk({tag, "_res"}, out_result, exp);
    endtask

    initial begin
        logic [4:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        r_fast;
        int          hits;

        arstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; operand_a = '0; operand_b = '0; rd_addr = '0;
        rd_write_en = 1'b0; dest_sel = '0; pc = '0;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_rd", 32'(out_rd_addr), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ctrl", 32'({out_rd_write_en, out_dest_sel}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD then SUB back-to-back with no bubble
        drive(5'd0, 32'd5, 32'd7, 5'd3, 32'h104, 32'd12);
        wait_accept("add");
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_res", out_result, 32'd12);
        chk("add_rd", 32'(out_rd_addr), 32'd3);
        chk("add_pc", out_pc, 32'h104);
        chk("add_ctrl", 32'({out_rd_write_en, out_dest_sel}), 32'b001);
        drive(5'd1, 32'd5, 32'd7, 5'd4, 32'h108, 32'hFFFFFFFE);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        wait_accept("sub");
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_res", out_result, 32'hFFFFFFFE);
        chk("sub_pc", out_pc, 32'h108);
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Directed ALU, M-extension and fast-path cases
        run_op("sra",    5'd7,  32'h80000000, 32'd4,        5'd5,  32'h10C, 32'hF8000000, 0);
        run_op("sll",    5'd2,  32'd1,        32'h3F,       5'd6,  32'h110, 32'h80000000, 0);
        run_op("slt",    5'd3,  32'hFFFFFFFF, 32'd1,        5'd7,  32'h114, 32'd1,        0);
        run_op("sltu",   5'd4,  32'hFFFFFFFF, 32'd1,        5'd8,  32'h118, 32'd0,        0);
        run_op("rsvd",   5'd20, 32'h1234,     32'h5678,     5'd9,  32'h11C, 32'd0,        0);
        run_op("mulh",   5'd11, 32'hFFFFFFFE, 32'd3,        5'd10, 32'h120, 32'hFFFFFFFF, 32);
        run_op("mul",    5'd10, 32'hFFFFFFFE, 32'd3,        5'd11, 32'h124, 32'hFFFFFFFA, 32);
        run_op("mulhsu", 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h128, 32'hFFFFFFFF, 32);
        run_op("mulhu",  5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h12C, 32'hFFFFFFFE, 32);
        run_op("div",    5'd14, 32'hFFFFFFF9, 32'd2,        5'd14, 32'h130, 32'hFFFFFFFD, 32);
        run_op("rem",    5'd16, 32'hFFFFFFF9, 32'd2,        5'd15, 32'h134, 32'hFFFFFFFF, 32);
        run_op("divu",   5'd15, 32'd100,      32'd7,        5'd16, 32'h138, 32'd14,       32);
        run_op("remu",   5'd17, 32'd100,      32'd7,        5'd17, 32'h13C, 32'd2,        32);
        run_op("divu_z", 5'd15, 32'd9,        32'd0,        5'd18, 32'h140, 32'hFFFFFFFF, 0);
        run_op("remu_z", 5'd17, 32'd5,        32'd0,        5'd19, 32'h144, 32'd5,        0);
        run_op("rem_ov", 5'd16, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h148, 32'd0,        0);
        run_op("div_ov", 5'd14, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h14C, 32'h80000000, 0);

        // Backpressure: pending result must hold while a new op waits
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(5'd9, 32'hF0F01234, 32'h0FF0FF00, 5'd22, 32'h150, 32'h00F01200);
        wait_accept("bp_and");
        drive(5'd8, 32'hF0F01234, 32'h0FF0FF00, 5'd23, 32'h154, 32'hFFF0FF34);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", out_result, 32'h00F01200);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_res", out_result, 32'hFFF0FF34);

        // Randomized ops, reference model supplies the expectation
        for (int i = 0; i < 12; i++) begin
            r_op = 5'($urandom_range(0, 19));
            r_a  = $urandom;
            r_b  = (i % 4 == 0) ? 32'd0 : $urandom;
            if (i % 5 == 1) r_b = $urandom_range(1, 9);
            r_fast = (r_op >= 5'd14) && (r_op <= 5'd17) && ((r_b == 0) ||
                     ((r_op == 5'd14 || r_op == 5'd16) && r_a == 32'h80000000 && r_b == 32'hFFFFFFFF));
            run_op("rand", r_op, r_a, r_b, 5'(i + 1), 32'h200 + 32'(i * 4),
                   ref_result(r_op, r_a, r_b),
                   ((r_op >= 5'd10) && (r_op <= 5'd17) && !r_fast) ? 32 : 0);
        end

        // Flush at counter 10 kills the divide
        set_in(5'd14, 32'd1000, 32'd3, 5'd24, 32'h300);
        wait_accept("flush_div");
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        chk("flush_ready_after", 32'(in_ready), 32'd1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        chk("flush_no_result", 32'(hits), 32'd0);

        // Reset at counter 20 aborts the divide and clears the outputs
        run_op("pre_rst", 5'd0, 32'h11, 32'h22, 5'd9, 32'h2004, 32'h33, 0);
        set_in(5'd14, 32'd1000, 32'd3, 5'd25, 32'h400);
        wait_accept("rst_div");
        repeat (20) @(posedge clk);
        #1;
        arstn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_rd", 32'(out_rd_addr), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_ctrl", 32'({out_rd_write_en, out_dest_sel}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        chk("arst_no_result", 32'(hits), 32'd0);
        run_op("post_rst", 5'd0, 32'd1, 32'd2, 5'd26, 32'h500, 32'd3, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
- Execute stage of the rv32imc pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its already-selected operands, ALU opcode and writeback control.
- Computes RV32I ALU results in one cycle.
- Computes RV32M multiply/divide/remainder with an iterative 32-step radix-2 unit.
- Registers the result plus writeback control into the EX/MEM boundary under a valid/ready handshake, stalling upstream while busy.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MD_STEPS, 32, iterations per M-extension operation. Must equal XLEN.

Ports:
- clk  input  1  clock, rising edge
- arstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of in-flight op and output register
- in_valid  input  1  ID/EX holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- alu_op  input  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 reserved
- operand_a  input  32  first operand (rs1 or pc, selected upstream)
- operand_b  input  32  second operand (rs2 or immediate)
- rd_addr  input  5  destination register
- rd_write_en  input  1  register-file write enable
- dest_sel  input  2  writeback source select, passed through unchanged
- pc  input  32  instruction pc, passed through
- out_valid  output  1  EX/MEM register holds a valid result
- out_ready  input  1  downstream consumes the result this cycle
- out_result  output  32  computed result
- out_rd_addr  output  5  registered rd_addr
- out_rd_write_en  output  1  registered rd_write_en
- out_dest_sel  output  2  registered dest_sel
- out_pc  output  32  registered pc

Behaviour:
- Clock is clk. Reset is arstn, asynchronous, active-low.
- Reset: state IDLE, step counter 0, all out_* = 0, out_valid = 0. in_ready is 1 once arstn is released. Reset during BUSY aborts the operation; no output is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Acceptance = in_valid && in_ready.
- Output register: hold while out_valid && !out_ready. It clears out_valid when out_ready is high and nothing new is loaded that edge.
- ALU ops (0-9, 18-31): result loaded on the acceptance edge, so out_valid rises 1 cycle after acceptance.
  - Shift amount = operand_b[4:0].
  - SLT/SLTU give 32'h0/32'h1.
  - Reserved ops give result 0 and otherwise pass through normally.
- M ops (10-17): the acceptance edge latches operands, sign flags, op and writeback control into internal registers, and sets state IDLE->BUSY, counter=0.
  - Each BUSY edge performs one shift-add (mul) or restoring shift-subtract (div) step on magnitudes, then counter++.
  - The edge with counter==31 applies sign correction, loads the output register, sets out_valid=1 and state->IDLE.
  - Latency: out_valid asserts exactly 32 cycles after the acceptance edge. in_ready stays 0 throughout BUSY.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL returns product[31:0]; MULH* return product[63:32].
  - REM takes the sign of the dividend.
- Division special cases take a fast path: the acceptance edge goes directly to the output register, so latency is 1 cycle.
  - Divide by zero: DIV/DIVU quotient = 32'hFFFFFFFF; REM/REMU remainder = operand_a.
  - Overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF): quotient 32'h80000000, remainder 0.
- Flush (synchronous, highest priority after reset):
  - Forces state IDLE and counter 0.
  - Clears out_valid. out_* data may keep stale values.
  - No acceptance in the flush cycle.
- Simultaneous out_ready and acceptance: the old result is consumed and the new one loaded on the same edge, with no bubble for ALU ops.
- Operand and control inputs are sampled only on the acceptance edge. Changes during BUSY are ignored.

Test Plan:
- Reset release, then ADD a=5 b=7, out_ready=1 -> out_valid high 1 cycle later, out_result=12, rd/pc passed through; back-to-back SUB 5-7 next cycle -> 32'hFFFFFFFE with no bubble.
- MULH a=32'hFFFFFFFE (-2) b=3 -> in_ready low for 32 cycles, out_result=32'hFFFFFFFF at cycle 32; MUL same operands -> 32'hFFFFFFFA.
- DIV a=-7 b=2 -> quotient 32'hFFFFFFFD; REM -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=9 b=0 -> 32'hFFFFFFFF after 1 cycle; REM a=32'h80000000 b=-1 -> 0 after 1 cycle.
- out_ready held 0 with result pending, in_valid=1 -> in_ready=0 and result stable for 5 cycles; then out_ready=1 -> next op accepted on the same edge.
- DIV started, flush asserted at counter=10 -> out_valid stays 0, in_ready=1 next cycle. Separately, arstn low at counter=20 -> all outputs 0, no late result.
